// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational from the fetch PC; resolved branches from EX train
// and allocate entries through the update port; btb_clear wipes the table.
//
// Optional feature macro: BTB_UPDATE_BYPASS_EN
//   When defined, an update whose index and tag match the current lookup is
//   forwarded to the outputs in the same cycle. When undefined, the update
//   becomes visible to lookup on the cycle after the edge.

module branch_target_buffer #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] btb_target_pc,
  output logic        btb_pc_valid,
  output logic        btb_pc_predictTaken,
  input  logic        update_en,
  input  logic [31:0] update_pc,
  input  logic [31:0] update_target,
  input  logic        update_taken,
  input  logic        btb_clear
);

  localparam int ENTRIES  = 2 ** INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  // Table state. Only valid and ctr are reset; tag and target are qualified by
  // valid and so are left unreset.
  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  logic [INDEX_BITS-1:0] lk_idx;
  logic [TAG_BITS-1:0]   lk_tag;
  logic                  lk_hit;

  logic [INDEX_BITS-1:0] up_idx;
  logic [TAG_BITS-1:0]   up_tag;
  logic                  up_hit;
  logic [1:0]            up_ctr_cur;
  logic [1:0]            up_ctr_next;
  logic                  up_write;

  // Byte-offset bits of both PCs play no part in indexing or tagging.
  logic unused_pc_low;
  assign unused_pc_low = ^{pc[1:0], update_pc[1:0]};

  assign lk_idx = pc[INDEX_BITS+1:2];
  assign lk_tag = pc[31:INDEX_BITS+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  assign up_idx     = update_pc[INDEX_BITS+1:2];
  assign up_tag     = update_pc[31:INDEX_BITS+2];
  assign up_hit     = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_ctr_cur = ctr_q[up_idx];

  // A not-taken miss is the only update that leaves the table untouched.
  assign up_write = update_en && (up_hit || update_taken);

  // Next counter value for the entry addressed by the update port.
  always_comb begin
    up_ctr_next = up_ctr_cur;
    if (up_hit) begin
      if (update_taken) begin
        if (up_ctr_cur != 2'b11) up_ctr_next = up_ctr_cur + 2'b01;
      end else begin
        if (up_ctr_cur != 2'b00) up_ctr_next = up_ctr_cur - 2'b01;
      end
    end else if (update_taken) begin
      up_ctr_next = 2'b10;
    end
  end

  // Table update: reset and clear both invalidate everything and return the
  // counters to weak-not-taken; an update in the same cycle is dropped.
  always_ff @(posedge clk) begin
    if (rst || btb_clear) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (up_write) begin
      valid_q[up_idx] <= 1'b1;
      tag_q[up_idx]   <= up_tag;
      ctr_q[up_idx]   <= up_ctr_next;
      if (update_taken) target_q[up_idx] <= update_target;
    end
  end

`ifdef BTB_UPDATE_BYPASS_EN
  logic fwd;
  logic fwd_valid;

  // Full index+tag match reduces to comparing pc[31:2] of both ports.
  assign fwd       = update_en && !btb_clear && (pc[31:2] == update_pc[31:2]);
  assign fwd_valid = up_hit || update_taken;

  // Lookup outputs, with the post-update entry substituted on a forward match.
  always_comb begin
    btb_pc_valid        = lk_hit;
    btb_pc_predictTaken = lk_hit && ctr_q[lk_idx][1];
    btb_target_pc       = lk_hit ? target_q[lk_idx] : 32'h0;
    if (fwd) begin
      btb_pc_valid        = fwd_valid;
      btb_pc_predictTaken = fwd_valid && up_ctr_next[1];
      if (!fwd_valid)        btb_target_pc = 32'h0;
      else if (update_taken) btb_target_pc = update_target;
      else                   btb_target_pc = target_q[lk_idx];
    end
  end
`else
  // Lookup outputs straight from registered table state.
  always_comb begin
    btb_pc_valid        = lk_hit;
    btb_pc_predictTaken = lk_hit && ctr_q[lk_idx][1];
    btb_target_pc       = lk_hit ? target_q[lk_idx] : 32'h0;
  end
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer (INDEX_BITS=4). The stimulus
// process drives one vector per cycle and queues the expected lookup result;
// the monitor pops and compares on the falling edge of the same cycle.

module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] btb_target_pc;
  logic        btb_pc_valid;
  logic        btb_pc_predictTaken;
  logic        update_en;
  logic [31:0] update_pc;
  logic [31:0] update_target;
  logic        update_taken;
  logic        btb_clear;

  typedef struct {
    bit        chk;
    bit        valid;
    bit        pt;
    bit [31:0] tgt;
  } exp_t;

  exp_t  exp_q  [$];
  string name_q [$];

  int checks = 0;
  int errors = 0;

  branch_target_buffer #(.INDEX_BITS(4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .pc                  (pc),
    .btb_target_pc       (btb_target_pc),
    .btb_pc_valid        (btb_pc_valid),
    .btb_pc_predictTaken (btb_pc_predictTaken),
    .update_en           (update_en),
    .update_pc           (update_pc),
    .update_target       (update_target),
    .update_taken        (update_taken),
    .btb_clear           (btb_clear)
  );

  always #5 clk = ~clk;

  // Monitor: compare the combinational lookup outputs mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      if (e.chk) begin
        checks++;
        if (btb_pc_valid !== e.valid || btb_pc_predictTaken !== e.pt ||
            btb_target_pc !== e.tgt) begin
          errors++;
          $display("FAIL %s: got valid=%0b pt=%0b tgt=%h, expected valid=%0b pt=%0b tgt=%h",
                   n, btb_pc_valid, btb_pc_predictTaken, btb_target_pc,
                   e.valid, e.pt, e.tgt);
        end
      end
    end
  end

  // One clock cycle of stimulus plus its expected lookup response.
  task automatic cyc(input string n, input bit r, input bit clr,
                     input logic [31:0] lpc,
                     input bit ue, input logic [31:0] upc,
                     input logic [31:0] utgt, input bit utk,
                     input bit chk, input bit ev, input bit ept,
                     input logic [31:0] etgt);
    exp_t e;
    rst           = r;
    btb_clear     = clr;
    pc            = lpc;
    update_en     = ue;
    update_pc     = upc;
    update_target = utgt;
    update_taken  = utk;
    e.chk   = chk;
    e.valid = ev;
    e.pt    = ept;
    e.tgt   = etgt;
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  // Lookup only, no update.
  task automatic look(input string n, input logic [31:0] lpc,
                      input bit ev, input bit ept, input logic [31:0] etgt);
    cyc(n, 1'b0, 1'b0, lpc, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, ev, ept, etgt);
  endtask

  // Update with a lookup pc chosen to miss, and expect all-zero outputs.
  task automatic upd(input string n, input logic [31:0] upc,
                     input logic [31:0] utgt, input bit utk);
    cyc(n, 1'b0, 1'b0, 32'h0000_003C, 1'b1, upc, utgt, utk, 1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    rst = 1'b1; btb_clear = 1'b0; pc = '0; update_en = 1'b0;
    update_pc = '0; update_target = '0; update_taken = 1'b0;
    @(posedge clk);
    #1;

    cyc("reset", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    for (int i = 0; i < 16; i++)
      look("sweep_after_reset", 32'(i * 4), 1'b0, 1'b0, 32'h0);

    // Allocation: ctr=10.
    upd("alloc_100", 32'h100, 32'h200, 1'b1);
    look("hit_100",   32'h100, 1'b1, 1'b1, 32'h200);
    look("hit_102",   32'h102, 1'b1, 1'b1, 32'h200);

    // Training: 10 -> 11 -> 11(sat) -> 10 -> 01 -> 00 -> 00(sat) -> 01 -> 10.
    upd("train_t1", 32'h100, 32'h200, 1'b1);
    upd("train_t2", 32'h100, 32'h200, 1'b1);
    look("ctr_11",  32'h100, 1'b1, 1'b1, 32'h200);
    upd("train_nt1", 32'h100, 32'h0, 1'b0);
    look("ctr_10",  32'h100, 1'b1, 1'b1, 32'h200);
    upd("train_nt2", 32'h100, 32'h0, 1'b0);
    look("ctr_01",  32'h100, 1'b1, 1'b0, 32'h200);
    upd("train_nt3", 32'h100, 32'h0, 1'b0);
    upd("train_nt4", 32'h100, 32'h0, 1'b0);
    look("ctr_00_sat", 32'h100, 1'b1, 1'b0, 32'h200);
    upd("train_t3", 32'h100, 32'h200, 1'b1);
    look("ctr_00_to_01", 32'h100, 1'b1, 1'b0, 32'h200);
    upd("train_t4", 32'h100, 32'h200, 1'b1);
    look("ctr_01_to_10", 32'h100, 1'b1, 1'b1, 32'h200);

    // Aliasing on index 0: tags 4 (0x100), 5 (0x140), 6 (0x180).
    look("alias_140_miss", 32'h140, 1'b0, 1'b0, 32'h0);
    upd("alloc_140", 32'h140, 32'h300, 1'b1);
    look("alias_140_hit",  32'h140, 1'b1, 1'b1, 32'h300);
    look("alias_100_evicted", 32'h100, 1'b0, 1'b0, 32'h0);
    upd("nt_miss_180", 32'h180, 32'h500, 1'b0);
    look("nt_miss_keeps_140", 32'h140, 1'b1, 1'b1, 32'h300);
    look("nt_miss_180_absent", 32'h180, 1'b0, 1'b0, 32'h0);

    // Clear beats a same-cycle update.
    cyc("clear_with_update", 1'b0, 1'b1, 32'h3C, 1'b1, 32'h100, 32'h200, 1'b1,
        1'b1, 1'b0, 1'b0, 32'h0);
    look("clear_140_miss", 32'h140, 1'b0, 1'b0, 32'h0);
    look("clear_100_miss", 32'h100, 1'b0, 1'b0, 32'h0);
    upd("realloc_100", 32'h100, 32'h200, 1'b1);
    look("realloc_ctr_10", 32'h100, 1'b1, 1'b1, 32'h200);
    upd("realloc_nt", 32'h100, 32'h0, 1'b0);
    look("realloc_ctr_01", 32'h100, 1'b1, 1'b0, 32'h200);

    // Same-cycle update and lookup of 0x100 (ctr 01 -> 10, target -> 0x204).
`ifdef BTB_UPDATE_BYPASS_EN
    cyc("same_cycle_upd", 1'b0, 1'b0, 32'h100, 1'b1, 32'h100, 32'h204, 1'b1,
        1'b1, 1'b1, 1'b1, 32'h204);
`else
    cyc("same_cycle_upd", 1'b0, 1'b0, 32'h100, 1'b1, 32'h100, 32'h204, 1'b1,
        1'b1, 1'b1, 1'b0, 32'h200);
`endif
    look("after_same_cycle", 32'h100, 1'b1, 1'b1, 32'h204);
    cyc("same_cycle_nt_miss", 1'b0, 1'b0, 32'h180, 1'b1, 32'h180, 32'h600, 1'b0,
        1'b1, 1'b0, 1'b0, 32'h0);

    // Reset mid-training drops everything.
    cyc("mid_reset", 1'b1, 1'b0, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0,
        1'b0, 1'b0, 1'b0, 32'h0);
    look("post_reset_100", 32'h100, 1'b0, 1'b0, 32'h0);
    look("post_reset_140", 32'h140, 1'b0, 1'b0, 32'h0);
    upd("post_reset_nt", 32'h100, 32'h0, 1'b0);
    look("post_reset_nt_no_alloc", 32'h100, 1'b0, 1'b0, 32'h0);

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected results left unchecked, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
